// File: rtl/imem_burst_responder_if.sv
// Line-fill request/response bus and backing-store load port for imem_burst_responder.
interface imem_burst_responder_if #(
  parameter int unsigned DEPTH_LOG2 = 10
);
  logic                  mem_req;
  logic [31:0]           mem_addr;
  logic [31:0]           mem_data;
  logic                  mem_val;
  logic                  ld_we;
  logic [DEPTH_LOG2-1:0] ld_addr;
  logic [31:0]           ld_data;
  logic                  busy;

  modport slave (
    input  mem_req, mem_addr, ld_we, ld_addr, ld_data,
    output mem_data, mem_val, busy
  );

  modport master (
    output mem_req, mem_addr, ld_we, ld_addr, ld_data,
    input  mem_data, mem_val, busy
  );
endinterface

// File: rtl/imem_burst_responder.sv
// Instruction-memory model: captures a line request, waits LATENCY cycles and
// streams the 8 words of the aligned line from a loadable backing store.
module imem_burst_responder #(
  parameter int unsigned LATENCY    = 2,
  parameter int unsigned BURST_LEN  = 8,
  parameter int unsigned DEPTH_LOG2 = 10
) (
  input  logic                    clk,
  input  logic                    reset,
  imem_burst_responder_if.slave   bus
);

  localparam int unsigned BEAT_W = $clog2(BURST_LEN);
  localparam int unsigned LINE_W = DEPTH_LOG2 - BEAT_W;
  localparam int unsigned DEPTH  = 1 << DEPTH_LOG2;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_BURST = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  logic [31:0]       store_q [DEPTH];
  state_t            state_q;
  logic [LINE_W-1:0] line_q;
  logic [BEAT_W-1:0] beat_q;
  logic [CNT_W-1:0]  wait_q;
  logic              mem_val_q;
  logic [31:0]       mem_data_q;

  // Backing store is never reset; writes land in any state.
  always_ff @(posedge clk) begin
    if (bus.ld_we) begin
      store_q[bus.ld_addr] <= bus.ld_data;
    end
  end

  // Request FSM; a same-edge load write is not seen by the beat read on that edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      line_q     <= '0;
      beat_q     <= '0;
      wait_q     <= '0;
      mem_val_q  <= 1'b0;
      mem_data_q <= '0;
    end else begin
      mem_val_q  <= 1'b0;
      mem_data_q <= '0;
      case (state_q)
        ST_IDLE: begin
          if (bus.mem_req) begin
            line_q <= bus.mem_addr[DEPTH_LOG2+1:5];
            beat_q <= '0;
            if (LATENCY == 0) begin
              state_q <= ST_BURST;
            end else begin
              wait_q  <= CNT_W'(LATENCY);
              state_q <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          wait_q <= wait_q - CNT_W'(1);
          if (wait_q == CNT_W'(1)) begin
            state_q <= ST_BURST;
          end
        end
        ST_BURST: begin
          mem_val_q  <= 1'b1;
          mem_data_q <= store_q[{line_q, beat_q}];
          beat_q     <= beat_q + BEAT_W'(1);
          if (beat_q == BEAT_W'(BURST_LEN - 1)) begin
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          // Trailing held request must not retrigger; wait for it to drop.
          if (!bus.mem_req) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.mem_val  = mem_val_q;
  assign bus.mem_data = mem_data_q;
  assign bus.busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_imem_burst_responder.sv
// Bench for imem_burst_responder: two instances (LATENCY=2/depth 1024, LATENCY=0/depth 16)
// checked every cycle against a timeline model plus directed literal expectations.
module tb_imem_burst_responder;

  localparam int unsigned LAT_A = 2;
  localparam int unsigned DEP_A = 10;
  localparam int unsigned LAT_B = 0;
  localparam int unsigned DEP_B = 4;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic        req  [2];
  logic [31:0] addr [2];
  logic        we   [2];
  logic [9:0]  la   [2];
  logic [31:0] ldd  [2];
  logic        val  [2];
  logic [31:0] dat  [2];
  logic        bsy  [2];

  imem_burst_responder_if #(.DEPTH_LOG2(DEP_A)) bif_a ();
  imem_burst_responder_if #(.DEPTH_LOG2(DEP_B)) bif_b ();

  imem_burst_responder #(.LATENCY(LAT_A), .BURST_LEN(8), .DEPTH_LOG2(DEP_A)) dut_a (
    .clk(clk), .reset(reset), .bus(bif_a));
  imem_burst_responder #(.LATENCY(LAT_B), .BURST_LEN(8), .DEPTH_LOG2(DEP_B)) dut_b (
    .clk(clk), .reset(reset), .bus(bif_b));

  assign bif_a.mem_req  = req[0];
  assign bif_a.mem_addr = addr[0];
  assign bif_a.ld_we    = we[0];
  assign bif_a.ld_addr  = la[0];
  assign bif_a.ld_data  = ldd[0];
  assign bif_b.mem_req  = req[1];
  assign bif_b.mem_addr = addr[1];
  assign bif_b.ld_we    = we[1];
  assign bif_b.ld_addr  = la[1][3:0];
  assign bif_b.ld_data  = ldd[1];
  assign val[0] = bif_a.mem_val;
  assign dat[0] = bif_a.mem_data;
  assign bsy[0] = bif_a.busy;
  assign val[1] = bif_b.mem_val;
  assign dat[1] = bif_b.mem_data;
  assign bsy[1] = bif_b.busy;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- timeline model ----------------
  int          lat_m [2] = '{2, 0};
  int          dep_m [2] = '{1024, 16};
  logic [31:0] shadow [2][1024];
  int          ph    [2] = '{0, 0};   // 0 idle, 1 serving, 2 waiting for req drop
  int          edg   [2] = '{0, 0};   // edges since capture
  int          base  [2] = '{0, 0};
  logic        ev    [2] = '{1'b0, 1'b0};
  logic [31:0] ed    [2] = '{32'h0, 32'h0};

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      ev[i] = 1'b0;
      ed[i] = 32'h0;
      if (reset) begin
        ph[i] = 0;
      end else if (ph[i] == 0) begin
        if (req[i]) begin
          base[i] = (int'(addr[i] >> 5) % (dep_m[i] / 8)) * 8;
          edg[i]  = 0;
          ph[i]   = 1;
        end
      end else if (ph[i] == 1) begin
        edg[i]++;
        if (edg[i] >= lat_m[i] + 1) begin
          ev[i] = 1'b1;
          ed[i] = shadow[i][(base[i] + edg[i] - lat_m[i] - 1) % dep_m[i]];
          if (edg[i] == lat_m[i] + 8) ph[i] = 2;
        end
      end else begin
        if (!req[i]) ph[i] = 0;
      end
      if (we[i]) shadow[i][int'(la[i]) % dep_m[i]] = ldd[i];
    end
  end

  // Compare every cycle on the falling edge.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        check($sformatf("cmp_val%0d", i),  32'(val[i]), 32'h0);
        check($sformatf("cmp_data%0d", i), dat[i],      32'h0);
        check($sformatf("cmp_busy%0d", i), 32'(bsy[i]), 32'h0);
      end else begin
        check($sformatf("cmp_val%0d", i),  32'(val[i]), 32'(ev[i]));
        check($sformatf("cmp_data%0d", i), dat[i],      ed[i]);
        check($sformatf("cmp_busy%0d", i), 32'(bsy[i]), 32'(ph[i] != 0));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One request; optional early drop, trailing hold and a load write to base+5 on edge we_edge.
  task automatic burst(input int i, input logic [31:0] a, input int hold, input bit drop_early,
                       input int we_edge, input logic [31:0] we_val,
                       output logic [31:0] beats [8], output int nval, output int first_n);
    int lat  = lat_m[i];
    int widx = (((int'(a >> 5) % (dep_m[i] / 8)) * 8) + 5) % dep_m[i];
    int last = lat + 8 + hold + 1;
    nval    = 0;
    first_n = -1;
    for (int k = 0; k < 8; k++) beats[k] = 32'h0;
    req[i]  = 1'b1;
    addr[i] = a;
    tick();
    if (drop_early) begin
      req[i]  = 1'b0;
      addr[i] = 32'hFFFF_FFE0;
    end
    for (int n = 1; n <= last; n++) begin
      if (n == we_edge) begin
        we[i]  = 1'b1;
        la[i]  = 10'(widx);
        ldd[i] = we_val;
      end
      if (n == last) req[i] = 1'b0;
      tick();
      we[i] = 1'b0;
      if (val[i]) begin
        if (first_n < 0) first_n = n;
        if (nval < 8) beats[nval] = dat[i];
        nval++;
      end
    end
  endtask

  logic [31:0] b  [8];
  logic [31:0] b2 [8];
  int nv, fn, nv2, fn2;

  initial begin
    for (int i = 0; i < 2; i++) begin
      req[i] = 1'b0; addr[i] = 32'h0; we[i] = 1'b0; la[i] = 10'h0; ldd[i] = 32'h0;
    end
    #2 reset = 1'b1;
    tick(); tick();
    check("rst_val",  32'(val[0]), 32'h0);
    check("rst_data", dat[0],      32'h0);
    check("rst_busy", 32'(bsy[0]), 32'h0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 32; i++) begin
      we[0] = 1'b1; la[0] = 10'(i); ldd[0] = 32'(i) * 32'h11;
      we[1] = (i < 16); la[1] = 10'(i % 16); ldd[1] = 32'hB000_0000 + 32'(i % 16);
      tick();
    end
    we[0] = 1'b0; we[1] = 1'b0;
    tick();

    // Nominal burst at 0x20
    burst(0, 32'h0000_0020, 0, 1'b0, 0, 32'h0, b, nv, fn);
    for (int k = 0; k < 8; k++) check("s1_beat", b[k], 32'h88 + 32'h11 * 32'(k));
    check("s1_nbeats", 32'(nv), 32'd8);
    check("s1_first",  32'(fn), 32'd3);
    check("s1_busy",   32'(bsy[0]), 32'h0);

    // Unaligned address with trailing request
    tick();
    burst(0, 32'h0000_003C, 2, 1'b0, 0, 32'h0, b, nv, fn);
    for (int k = 0; k < 8; k++) check("s2_beat", b[k], 32'h88 + 32'h11 * 32'(k));
    check("s2_nbeats", 32'(nv), 32'd8);
    check("s2_busy",   32'(bsy[0]), 32'h0);
    repeat (4) tick();

    // Load-write collisions on word base+5 (index 21)
    burst(0, 32'h0000_0040, 0, 1'b0, LAT_A + 4, 32'hDEAD_0001, b, nv, fn);
    check("s5_beat4_pre", b[4], 32'h154);
    check("s5_beat5_new", b[5], 32'hDEAD_0001);
    tick();
    burst(0, 32'h0000_0040, 0, 1'b0, LAT_A + 6, 32'hBEEF_0002, b, nv, fn);
    check("s5_beat5_old", b[5], 32'hDEAD_0001);
    tick();
    burst(0, 32'h0000_0040, 0, 1'b0, 0, 32'h0, b, nv, fn);
    check("s5_beat5_late", b[5], 32'hBEEF_0002);
    check("s5_beat7",      b[7], 32'h187);
    tick();

    // Reset during beat 4
    req[0] = 1'b1; addr[0] = 32'h0;
    tick();
    repeat (7) tick();
    check("s6_beat4_val",  32'(val[0]), 32'h1);
    check("s6_beat4_data", dat[0],      32'h44);
    reset = 1'b1;
    #1;
    check("s6_rst_val",  32'(val[0]), 32'h0);
    check("s6_rst_data", dat[0],      32'h0);
    check("s6_rst_busy", 32'(bsy[0]), 32'h0);
    req[0] = 1'b0;
    tick(); tick();
    reset = 1'b0;
    tick();
    burst(0, 32'h0, 0, 1'b0, 0, 32'h0, b, nv, fn);
    for (int k = 0; k < 8; k++) check("s6_beat", b[k], 32'h11 * 32'(k));
    check("s6_nbeats", 32'(nv), 32'd8);
    check("s6_first",  32'(fn), 32'd3);
    tick();

    // Zero latency, back-to-back requests
    burst(1, 32'h0, 0, 1'b0, 0, 32'h0, b, nv, fn);
    burst(1, 32'h0, 0, 1'b0, 0, 32'h0, b2, nv2, fn2);
    for (int k = 0; k < 8; k++) check("s4_beat", b[k], 32'hB000_0000 + 32'(k));
    check("s4_first",   32'(fn),  32'd1);
    check("s4_first2",  32'(fn2), 32'd1);
    check("s4_nbeats2", 32'(nv2), 32'd8);
    check("s4_b2beat0", b2[0], 32'hB000_0000);
    check("s4_b2beat7", b2[7], 32'hB000_0007);
    tick();

    // Wrap-around in 16-word store, request dropped and address changed early
    burst(1, 32'h0000_0060, 0, 1'b1, 0, 32'h0, b, nv, fn);
    for (int k = 0; k < 8; k++) check("s3_beat", b[k], 32'hB000_0008 + 32'(k));
    check("s3_nbeats", 32'(nv), 32'd8);
    check("s3_busy",   32'(bsy[1]), 32'h0);
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/imem_burst_responder.md
IMEM_BURST_RESPONDER -- requirements
Module: imem_burst_responder

Interface
REQ-001 Parameter LATENCY, default 2: wait cycles between request capture and the first data beat; legal range 0..15.
REQ-002 Parameter BURST_LEN, default 8: words per burst; fixed at 8 for the 32-byte line.
REQ-003 Parameter DEPTH_LOG2, default 10: backing store holds 2^DEPTH_LOG2 32-bit words.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 mem_req  input  1  line-fill request, level-held by the requester.
REQ-007 mem_addr  input  32  byte address of the requested line.
REQ-008 mem_data  output  32  burst data word, registered.
REQ-009 mem_val  output  1  mem_data valid this cycle, registered.
REQ-010 ld_we  input  1  backing-store load write enable.
REQ-011 ld_addr  input  DEPTH_LOG2  word index for the load write.
REQ-012 ld_data  input  32  load write data.
REQ-013 busy  output  1  high in any state other than IDLE.

Function
REQ-014 The block SHALL implement four states: IDLE, WAIT, BURST, DONE.
REQ-015 In IDLE, a rising edge with mem_req=1 SHALL capture base = mem_addr[DEPTH_LOG2+1:5] concatenated with 3'b000 as the word index; mem_addr[4:0] SHALL be ignored.
REQ-016 On capture, the block SHALL go to WAIT with the wait counter set to LATENCY when LATENCY>0, and directly to BURST when LATENCY=0.
REQ-017 WAIT SHALL decrement the counter once per cycle and move to BURST when the counter reaches 1.
REQ-018 The first mem_val SHALL be asserted LATENCY+1 cycles after the capture edge.
REQ-019 In BURST, the block SHALL assert mem_val for exactly BURST_LEN consecutive cycles with no gaps.
REQ-020 Beat k (0..7) SHALL carry the word at index base+k, in ascending order, so that word 0 is delivered first.
REQ-021 Word indices SHALL be taken modulo 2^DEPTH_LOG2, so addresses beyond the store depth alias.
REQ-022 mem_data SHALL be 0 whenever mem_val=0.
REQ-023 After the last beat, the block SHALL enter DONE and stay there while mem_req=1.
REQ-024 The block SHALL return from DONE to IDLE on the first edge with mem_req=0; the requester holds mem_req for up to 2 cycles after the last beat, and these trailing cycles SHALL NOT start a new burst.
REQ-025 A new request SHALL be accepted no earlier than the first edge in IDLE with mem_req=1, which is at least one cycle after DONE exits.
REQ-026 Deassertion of mem_req during WAIT or BURST SHALL be ignored; the burst SHALL always complete all BURST_LEN beats.
REQ-027 mem_addr changes after capture SHALL have no effect on the burst in progress.
REQ-028 ld_we=1 SHALL write ld_data to word ld_addr in any state.
REQ-029 When a load write and a burst read hit the same word on the same edge, the burst SHALL return the old value.
REQ-030 A load write to a burst word not yet read SHALL be visible when that word's beat is read.
REQ-031 busy SHALL be combinationally derived from state, high in WAIT, BURST and DONE.

Reset
REQ-032 Asserting reset SHALL immediately force state=IDLE, mem_val=0, mem_data=0, busy=0 and clear the wait and beat counters, without waiting for a clock edge.
REQ-033 The backing store SHALL NOT be cleared by reset.
REQ-034 Reset asserted mid-burst SHALL abort the burst: mem_val drops in the same cycle and no further beats are issued.
REQ-035 After reset deasserts, the first request SHALL be captured by the first edge in IDLE with mem_req=1.

Verification
REQ-036 Scenario 1, nominal burst: store[i]=i*0x11 for i=0..31, LATENCY=2, mem_req=1 with mem_addr=0x0000_0020 -> mem_val high on cycles 3..10 after capture, carrying 0x88, 0x99, ... 0xFF; busy low after mem_req drops.
REQ-037 Scenario 2, unaligned address and trailing request: mem_addr=0x0000_003C with mem_req held 2 cycles past the last beat -> same 8 words starting at index 8; exactly one burst issued; state returns to IDLE.
REQ-038 Scenario 3, wrap-around: DEPTH_LOG2=4, mem_addr=0x0000_0060 -> words at indices 8..15 returned, aliasing index 24 down to 8.
REQ-039 Scenario 4, zero latency and back-to-back requests: LATENCY=0 -> first mem_val on the cycle after capture; a second request issued after one cycle of mem_req=0 is served with identical timing.
REQ-040 Scenario 5, load-write collisions: ld_we=1 targets index base+5 during beat 2 -> beat 5 carries the new ld_data; ld_we=1 on the exact edge beat 5 is read -> beat 5 carries the old value.
REQ-041 Scenario 6, reset mid-burst: reset asserted during beat 4 -> mem_val and mem_data are 0 immediately; the next request after release returns a full 8-beat burst; store contents are intact.
